// File: rtl/bin_avg_pkg.sv
// rtl/bin_avg_pkg.sv - shared types, defaults and helpers for the bin averaging sequencer
package bin_avg_pkg;

  localparam int DEF_MAX_N_AVGS = 7;
  localparam int DEF_CNT_W      = 3;
  localparam int DEF_FRM_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ACCUM = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Limit a requested log2 average count to the largest supported value.
  function automatic int unsigned clamp_n(input int unsigned cfg, input int unsigned max_n);
    return (cfg > max_n) ? max_n : cfg;
  endfunction

endpackage

// File: rtl/bin_avg_frame_cnt.sv
// rtl/bin_avg_frame_cnt.sv - frame counter with terminal-count compare against 2^n - 1
//   clk, arest_n : clock, synchronous active-low reset
//   clr          : force the count to zero (has priority over inc)
//   inc          : advance the count by one frame
//   n            : log2 of the window length in frames
//   tc           : count equals 2^n - 1, i.e. the current frame closes the window
module bin_avg_frame_cnt
  import bin_avg_pkg::*;
#(
  parameter int MAX_N_AVGS = DEF_MAX_N_AVGS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             arest_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] n,
  output logic             tc
);

  localparam int CW = MAX_N_AVGS + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] last_val;

  // n never exceeds MAX_N_AVGS, so 1 << n always fits in CW bits.
  assign last_val = (CW'(1) << n) - CW'(1);
  assign tc       = (cnt == last_val);

  always_ff @(posedge clk) begin
    if (!arest_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bin_avg_ctrl.sv
// rtl/bin_avg_ctrl.sv - sequencer framing FFT beats into 2^n-frame averaging windows
//   Optional macro BIN_AVG_CTRL_PEAK_HOLD_EN adds the overrun_cnt status output.
//   clk, arest_n       : clock, synchronous active-low reset
//   cfg_n_avgs         : log2 frames per window, sampled on an accepted start
//   cfg_continuous     : re-arm after each readout, sampled on an accepted start
//   start, stop        : single-cycle commands (stop wins)
//   fft_valid/fft_last : FFT beat stream framing
//   avg_clear/avg_en   : accumulator clear pulse and per-beat accumulate strobe
//   avg_n_avgs         : latched, clamped average count
//   out_valid/out_ready: result-ready handshake to the readout
//   busy               : sequencer not idle
//   overrun            : one-cycle pulse per frame dropped while holding a result
//   frames_done        : completed window count (wraps)
//   overrun_cnt        : saturating overrun pulse count (optional)
module bin_avg_ctrl
  import bin_avg_pkg::*;
#(
  parameter int MAX_N_AVGS = DEF_MAX_N_AVGS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FRM_W      = DEF_FRM_W
) (
  input  logic             clk,
  input  logic             arest_n,
  input  logic [CNT_W-1:0] cfg_n_avgs,
  input  logic             cfg_continuous,
  input  logic             start,
  input  logic             stop,
  input  logic             fft_valid,
  input  logic             fft_last,
  output logic             avg_clear,
  output logic             avg_en,
  output logic [CNT_W-1:0] avg_n_avgs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic [FRM_W-1:0] frames_done
`ifdef BIN_AVG_CTRL_PEAK_HOLD_EN
  ,
  output logic [15:0]      overrun_cnt
`endif
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_lat, n_nxt;
  logic             cont_lat, cont_nxt;
  logic             clear_nxt;
  logic             valid_nxt;
  logic             overrun_nxt;
  logic [FRM_W-1:0] done_nxt;
  logic             frame_end;
  logic             start_acc;
  logic             tc;

  assign frame_end  = fft_valid & fft_last;
  assign start_acc  = (state == IDLE) & start & ~stop;
  assign avg_en     = (state == ACCUM) & fft_valid;
  assign busy       = (state != IDLE);
  assign avg_n_avgs = n_lat;

  // The counter only runs inside a window; anywhere else it sits at zero so
  // the first frame after ARM realigns is frame 0.
  bin_avg_frame_cnt #(
    .MAX_N_AVGS (MAX_N_AVGS),
    .CNT_W      (CNT_W)
  ) u_frame_cnt (
    .clk     (clk),
    .arest_n (arest_n),
    .clr     (state != ACCUM),
    .inc     ((state == ACCUM) & frame_end & ~tc),
    .n       (n_lat),
    .tc      (tc)
  );

  always_comb begin
    state_nxt   = state;
    n_nxt       = n_lat;
    cont_nxt    = cont_lat;
    clear_nxt   = 1'b0;
    valid_nxt   = out_valid;
    overrun_nxt = 1'b0;
    done_nxt    = frames_done;

    case (state)
      IDLE: begin
        if (start_acc) begin
          n_nxt     = CNT_W'(clamp_n(32'(cfg_n_avgs), 32'(MAX_N_AVGS)));
          cont_nxt  = cfg_continuous;
          clear_nxt = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (frame_end) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (frame_end && tc) begin
          state_nxt = HOLD;
          valid_nxt = 1'b1;
        end
      end
      HOLD: begin
        overrun_nxt = frame_end;
        if (out_valid && out_ready) begin
          done_nxt  = frames_done + FRM_W'(1);
          valid_nxt = 1'b0;
          if (cont_lat && !stop) begin
            clear_nxt = 1'b1;
            state_nxt = ARM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort from anywhere; a handshake completing in the same cycle still counts.
    if (stop) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
      clear_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!arest_n) begin
      state       <= IDLE;
      n_lat       <= '0;
      cont_lat    <= 1'b0;
      avg_clear   <= 1'b0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      frames_done <= '0;
    end else begin
      state       <= state_nxt;
      n_lat       <= n_nxt;
      cont_lat    <= cont_nxt;
      avg_clear   <= clear_nxt;
      out_valid   <= valid_nxt;
      overrun     <= overrun_nxt;
      frames_done <= done_nxt;
    end
  end

`ifdef BIN_AVG_CTRL_PEAK_HOLD_EN
  always_ff @(posedge clk) begin
    if (!arest_n) begin
      overrun_cnt <= '0;
    end else if (start_acc) begin
      overrun_cnt <= '0;
    end else if (overrun && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

endmodule
